frame_scheduler: RTL and testbench

- Sequences each game frame for the block-stacking datapath.
- Owns the frame-rate down-counter and the level-dependent frame period.
- On each frame tick, runs three phases in order (erase, update, draw), each through a req/done handshake with its datapath unit.
- Sits between the top-level game FSM and the erase/update/draw units; replaces hand-wired fps_count constants.

---
 rtl/frame_pkg.sv | 17 +
 rtl/frame_tick_counter.sv | 45 ++++
 rtl/frame_scheduler.sv | 143 ++++++++++++++
 tb/tb_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and default timing constants for the frame scheduler.
// Defaults assume a 50 MHz clock: base 15 fps, floor 60 fps.
package frame_pkg;

   localparam int unsigned DefCntW        = 23;
   localparam int unsigned DefPeriodBase  = 3333333;
   localparam int unsigned DefPeriodStep  = 416666;
   localparam int unsigned DefPeriodMin   = 833332;

   typedef enum logic [1:0] {
      StIdle,
      StErase,
      StUpdate,
      StDraw
   } frame_state_e;

endpackage

// File: rtl/frame_tick_counter.sv
// Frame-rate down-counter: reloads from the live period on reaching zero and emits a
// one-cycle tick; a load forces a new count and suppresses that cycle's tick.
module frame_tick_counter
   import frame_pkg::*;
#(
   parameter int unsigned         CNT_W     = DefCntW,
   parameter logic [CNT_W-1:0]    RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   localparam logic [CNT_W-1:0] One = CNT_W'(1);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (load) begin
         cnt_d = load_val;
      end else if (enable) begin
         if (cnt_q == '0) begin
            cnt_d = period;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q - One;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= RESET_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: tick -> erase -> update -> draw via req/done handshakes.
// Define FRAME_OVERRUN_COUNT_EN to add a saturating overrun_count output.
module frame_scheduler
   import frame_pkg::*;
#(
   parameter int unsigned CNT_W       = DefCntW,
   parameter int unsigned PERIOD_BASE = DefPeriodBase,
   parameter int unsigned PERIOD_STEP = DefPeriodStep,
   parameter int unsigned PERIOD_MIN  = DefPeriodMin
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             new_game,
   input  logic             level_up,
   output logic             erase_req,
   input  logic             erase_done,
   output logic             update_req,
   input  logic             update_done,
   output logic             draw_req,
   input  logic             draw_done,
   output logic [CNT_W-1:0] frame_period,
   output logic             busy,
   output logic             overrun
`ifdef FRAME_OVERRUN_COUNT_EN
   ,
   output logic [7:0]       overrun_count
`endif
);

   localparam logic [CNT_W-1:0] BaseVal = CNT_W'(PERIOD_BASE);
   localparam logic [CNT_W-1:0] StepVal = CNT_W'(PERIOD_STEP);
   localparam logic [CNT_W-1:0] MinVal  = CNT_W'(PERIOD_MIN);

   frame_state_e     state_d, state_q;
   logic [CNT_W-1:0] frame_period_d, frame_period_q;
   logic             erase_req_d, erase_req_q;
   logic             update_req_d, update_req_q;
   logic             draw_req_d, draw_req_q;
   logic             busy_d, busy_q;
   logic             overrun_d, overrun_q;
   logic [CNT_W:0]   period_diff;
   logic             tick;

   frame_tick_counter #(
      .CNT_W     (CNT_W),
      .RESET_VAL (BaseVal)
   ) u_tick_counter (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .load     (new_game),
      .load_val (BaseVal),
      .period   (frame_period_q),
      .tick     (tick)
   );

   // Extra MSB catches a borrow so the period never wraps below the floor.
   always_comb begin
      period_diff    = {1'b0, frame_period_q} - {1'b0, StepVal};
      frame_period_d = frame_period_q;
      if (new_game) begin
         frame_period_d = BaseVal;
      end else if (level_up) begin
         if (period_diff[CNT_W] || (period_diff[CNT_W-1:0] < MinVal)) begin
            frame_period_d = MinVal;
         end else begin
            frame_period_d = period_diff[CNT_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (tick)                        state_d = StErase;
         StErase:  if (erase_done && erase_req_q)   state_d = StUpdate;
         StUpdate: if (update_done && update_req_q) state_d = StDraw;
         StDraw:   if (draw_done && draw_req_q)     state_d = StIdle;
         default:                                   state_d = StIdle;
      endcase
      if (new_game) begin
         state_d = StIdle;
      end
      // A tick while busy is reported and dropped; new_game already masks the tick.
      overrun_d    = tick && (state_q != StIdle);
      erase_req_d  = (state_d == StErase);
      update_req_d = (state_d == StUpdate);
      draw_req_d   = (state_d == StDraw);
      busy_d       = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         frame_period_q <= BaseVal;
         erase_req_q    <= 1'b0;
         update_req_q   <= 1'b0;
         draw_req_q     <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_period_q <= frame_period_d;
         erase_req_q    <= erase_req_d;
         update_req_q   <= update_req_d;
         draw_req_q     <= draw_req_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
      end
   end

   assign erase_req    = erase_req_q;
   assign update_req   = update_req_q;
   assign draw_req     = draw_req_q;
   assign frame_period = frame_period_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;

`ifdef FRAME_OVERRUN_COUNT_EN
   logic [7:0] ovr_cnt_d, ovr_cnt_q;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (new_game) begin
         ovr_cnt_d = 8'd0;
      end else if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
         ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_cnt_q <= 8'd0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a short period (base 9, step 3, floor 2).
module tb_frame_scheduler;

   localparam int unsigned CNT_W = 23;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b1;
   logic             new_game = 1'b0;
   logic             level_up = 1'b0;
   logic             erase_done = 1'b0;
   logic             update_done = 1'b0;
   logic             draw_done = 1'b0;
   logic             erase_req, update_req, draw_req;
   logic [CNT_W-1:0] frame_period;
   logic             busy, overrun;
`ifdef FRAME_OVERRUN_COUNT_EN
   logic [7:0]       overrun_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic auto_erase = 1'b1;
   logic man_erase  = 1'b0;
   logic man_draw   = 1'b0;
   int   e_age = 0, u_age = 0, d_age = 0;

   frame_scheduler #(
      .CNT_W       (CNT_W),
      .PERIOD_BASE (9),
      .PERIOD_STEP (3),
      .PERIOD_MIN  (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .new_game     (new_game),
      .level_up     (level_up),
      .erase_req    (erase_req),
      .erase_done   (erase_done),
      .update_req   (update_req),
      .update_done  (update_done),
      .draw_req     (draw_req),
      .draw_done    (draw_done),
      .frame_period (frame_period),
      .busy         (busy),
      .overrun      (overrun)
`ifdef FRAME_OVERRUN_COUNT_EN
      ,
      .overrun_count (overrun_count)
`endif
   );

   always #5 clk = ~clk;

   // Responder: raise done one cycle after each req, so every req is high two cycles.
   always @(negedge clk) begin
      e_age = erase_req  ? e_age + 1 : 0;
      u_age = update_req ? u_age + 1 : 0;
      d_age = draw_req   ? d_age + 1 : 0;
      erase_done  = (auto_erase && (e_age >= 2)) || man_erase;
      update_done = (u_age >= 2);
      draw_done   = (d_age >= 2) || man_draw;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edges until erase_req rises; -1 if it never does within the budget.
   task automatic wait_erase(output int n);
      logic prev;
      bit   found;
      prev  = erase_req;
      found = 1'b0;
      n     = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1);
         n++;
         if (erase_req && !prev) found = 1'b1;
         prev = erase_req;
      end
      if (!found) n = -1;
   endtask

   task automatic wait_overrun(output int n);
      bit found;
      found = 1'b0;
      n     = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         n++;
         if (overrun) found = 1'b1;
      end
      if (!found) n = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic pulse_level();
      level_up = 1'b1;
      step(1);
      level_up = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int ov_cnt, ov_first, ov_second, busy_drop;
      logic [3:0] seq_exp [6];
      seq_exp = '{4'b1001, 4'b0101, 4'b0101, 4'b0011, 4'b0011, 4'b0000};

      // Reset state and steady frame cadence
      do_reset();
      check_eq("rst_reqs", 32'({erase_req, update_req, draw_req}), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      check_eq("rst_period", 32'(frame_period), 32'd9);
      wait_erase(n);
      check_eq("first_tick", n, 32'd10);
      for (int i = 0; i < 6; i++) begin
         step(1);
         check_eq($sformatf("seq_%0d", i + 1),
                  32'({erase_req, update_req, draw_req, busy}), 32'(seq_exp[i]));
      end
      wait_erase(n);
      check_eq("tick_spacing", n, 32'd4);

      // level_up x3: 9 -> 6 -> 3 -> 2 (floor); running count is untouched
      pulse_level();
      check_eq("level_1", 32'(frame_period), 32'd6);
      pulse_level();
      check_eq("level_2", 32'(frame_period), 32'd3);
      pulse_level();
      check_eq("level_3_sat", 32'(frame_period), 32'd2);
      wait_erase(n);
      check_eq("old_period_tick", n, 32'd7);
      wait_overrun(n);
      check_eq("new_period_tick", n, 32'd3);

      // Stalled erase: ticks 2 and 3 overrun and are dropped
      do_reset();
      check_eq("rst_period_restore", 32'(frame_period), 32'd9);
      auto_erase = 1'b0;
      wait_erase(n);
      check_eq("stall_first_tick", n, 32'd10);
      ov_cnt = 0; ov_first = -1; ov_second = -1; busy_drop = 0;
      for (int i = 1; i <= 25; i++) begin
         step(1);
         if (!busy) busy_drop++;
         if (overrun) begin
            ov_cnt++;
            if (ov_first < 0) ov_first = i;
            else ov_second = i;
         end
      end
      check_eq("stall_ovr_count", ov_cnt, 32'd2);
      check_eq("stall_ovr_first", ov_first, 32'd10);
      check_eq("stall_ovr_second", ov_second, 32'd20);
      check_eq("stall_busy_drop", busy_drop, 32'd0);
      check_eq("stall_erase_held", 32'(erase_req), 32'd1);
      man_erase = 1'b1;
      step(1);
      man_erase = 1'b0;
      check_eq("stall_release", 32'({erase_req, update_req}), 32'b01);
      step(1);
      check_eq("stall_no_extra_erase", 32'(erase_req), 32'd0);
      auto_erase = 1'b1;

      // enable low 5 cycles mid-count
      do_reset();
      wait_erase(n);
      check_eq("en_first_tick", n, 32'd10);
      step(3);
      enable = 1'b0;
      step(2);
      check_eq("en_off_draw", 32'(draw_req), 32'd1);
      step(3);
      check_eq("en_off_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_erase(n);
      check_eq("en_delayed_tick", n, 32'd7);

      // new_game with level_up during UPDATE
      pulse_level();
      check_eq("ng_pre_level", 32'(frame_period), 32'd6);
      step(1);
      check_eq("ng_in_update", 32'(update_req), 32'd1);
      new_game = 1'b1;
      level_up = 1'b1;
      step(1);
      new_game = 1'b0;
      level_up = 1'b0;
      check_eq("ng_reqs", 32'({erase_req, update_req, draw_req}), 32'd0);
      check_eq("ng_busy", 32'(busy), 32'd0);
      check_eq("ng_period", 32'(frame_period), 32'd9);
      wait_erase(n);
      check_eq("ng_next_tick", n, 32'd10);

      // Reset during DRAW; a late draw_done is ignored
      pulse_level();
      check_eq("rd_level", 32'(frame_period), 32'd6);
      step(3);
      check_eq("rd_in_draw", 32'(draw_req), 32'd1);
      reset = 1'b1;
      step(1);
      check_eq("rd_reqs", 32'({erase_req, update_req, draw_req}), 32'd0);
      check_eq("rd_period", 32'(frame_period), 32'd9);
      check_eq("rd_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      man_draw = 1'b1;
      step(2);
      man_draw = 1'b0;
      check_eq("rd_late_done", 32'({busy, draw_req, update_req}), 32'd0);
      wait_erase(n);
      check_eq("rd_restart_tick", n, 32'd8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
